cla_multiword_seq: RTL and testbench
====================================

// Module: cla_multiword_seq
// PURPOSE
//  Multi-cycle wide adder. Time-shares one 16-bit carry-lookahead adder slice (4x 4-bit CLA groups) over a W-bit add.
//  Operands are captured on a valid/ready handshake, then one 16-bit chunk is added per cycle, LSB chunk first.
//  A registered carry links each chunk to the next. The result is held under valid/ready until consumed.
//  Sits between wide-operand producers (accumulators, address generators) and the 16-bit CLA datapath.
// PARAMETERS
//  W      64   total operand/result width; must be a multiple of 16 and >= 16
//  CHUNK  16   chunk width; fixed to the CLA slice width, must not be overridden
//  NCH    W/16 derived localparam, number of chunks; counter width clog2(NCH), min 1
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operands A/B/Cin valid
//  in_ready   out  1  block can accept operands
//  A          in   W  operand A
//  B          in   W  operand B
//  Cin        in   1  carry-in to chunk 0
//  Sub        in   1  subtract request (only when CLA_SEQ_SUB_EN is defined)
//  out_valid  out  1  S/Cout/Ovf valid
//  out_ready  in   1  consumer accepts result
//  S          out  W  sum, registered
//  Cout       out  1  carry out of bit W-1, registered
//  Ovf        out  1  two's-complement signed overflow, registered
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, carry=0, S=0, Cout=0, Ovf=0, out_valid=0; in_ready=0 while rst is high.
//  Reset mid-operation aborts the add. No out_valid is produced. Captured operands are discarded.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, capture A,B into regs; carry<=Cin; idx<=0; go to RUN.
//   RUN: in_ready=0.
//     Each cycle: {c,s} = A[idx*16+:16] + B[idx*16+:16] + carry, computed by the CLA slice.
//     Then S[idx*16+:16]<=s; carry<=c; idx<=idx+1.
//     When idx==NCH-1: Cout<=c; Ovf<=(A[W-1]==B[W-1])&(s[15]!=A[W-1]); go to DONE.
//   DONE: out_valid=1; S, Cout and Ovf are held stable. On out_ready, go to IDLE (out_valid falls).
//  Latency: acceptance edge k gives out_valid=1 after edge k+NCH.
//   NCH=1 gives a single RUN cycle.
//  Throughput: one op per NCH+2 cycles (capture, NCH chunks, handshake).
//  S is written chunk-by-chunk during RUN. It is only meaningful while out_valid=1.
//  in_valid outside IDLE is ignored. A/B may change after capture without effect.
//  out_ready asserted outside DONE has no effect.
//  Carry propagates across chunk boundaries through the carry register only. The full W-bit wrap gives Cout=1.
// CONFIGURATION
//  CLA_SEQ_SUB_EN defined:
//   Sub port exists and is captured with the operands.
//   Sub=1: operand B is stored as ~B and the initial carry is forced to 1 (Cin is ignored). Result S=A-B.
//   Cout=1 means no borrow. Ovf uses the inverted B MSB.
//  CLA_SEQ_SUB_EN undefined: no Sub port; add only.
// TESTING
//  W=64, A=64'hFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> S=0, Cout=1, Ovf=0; out_valid exactly 4 cycles after accept.
//  A=64'h7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> S=64'h8000_0000_0000_0000, Cout=0, Ovf=1.
//  Result with out_ready=0 for 5 cycles -> S/Cout/Ovf stable, in_ready=0, in_valid pulses ignored; completes on out_ready=1.
//  rst pulsed during RUN after 2 chunks -> out_valid stays 0, in_ready=1 after release; next op A=1,B=2 -> S=3.
//  out_ready tied 1, in_valid held with ops (10+20) then (3+4) -> S=30 then S=7; accept edges 6 cycles apart.
//  CLA_SEQ_SUB_EN defined: A=5, B=7, Sub=1 -> S=64'hFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0.

Source files
------------

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: multi-cycle W-bit adder built on one shared 16-bit
// carry-lookahead slice made of four 4-bit CLA groups.
//
// The operands are captured on an in_valid/in_ready handshake. One 16-bit
// chunk is then added per cycle, starting with the least significant chunk.
// A registered carry links each chunk to the next one. The result is held
// under out_valid/out_ready until the consumer takes it.
//
// Optional feature macro: CLA_SEQ_SUB_EN
//   When it is defined, the Sub port exists. With Sub=1 the block computes
//   A-B: B is stored inverted and the initial carry is forced to 1.
//   In that mode Cout=1 means no borrow occurred.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any operation)
//   in_valid   A/B/Cin (and Sub) valid
//   in_ready   block can accept operands (IDLE only, low while rst is high)
//   A, B       W-bit operands
//   Cin        carry into chunk 0
//   Sub        subtract request (CLA_SEQ_SUB_EN only)
//   out_valid  S/Cout/Ovf valid
//   out_ready  consumer accepts result
//   S          W-bit sum, registered, meaningful only while out_valid=1
//   Cout       carry out of bit W-1, registered
//   Ovf        two's-complement signed overflow, registered
module cla_multiword_seq #(
    parameter int W     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic         Sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         Ovf
);

    localparam int NCH = W / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NG  = CHUNK / 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           last;

    // CLA slice signals
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] cs;
    logic [CHUNK:0]   c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;

    assign last = (idx == IW'(NCH - 1));

    // One 16-bit CLA slice. Each 4-bit group produces a group generate and a
    // group propagate signal. The group carries are formed from these two
    // signals. The carries inside each group are then looked ahead from the
    // carry that enters the group.
    always_comb begin
        ca = a_reg[idx*CHUNK +: CHUNK];
        cb = b_reg[idx*CHUNK +: CHUNK];
        g  = ca & cb;
        p  = ca ^ cb;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        gc[0] = carry;
        for (int unsigned j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);

            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[CHUNK] = gc[NG];
        cs = p ^ c[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_reg <= A;
                idx   <= '0;
`ifdef CLA_SEQ_SUB_EN
                b_reg <= Sub ? ~B : B;
                carry <= Sub ? 1'b1 : Cin;
`else
                b_reg <= B;
                carry <= Cin;
`endif
            end else if (state == RUN) begin
                S[idx*CHUNK +: CHUNK] <= cs;
                carry <= c[CHUNK];
                idx   <= idx + IW'(1);
                if (last) begin
                    Cout <= c[CHUNK];
                    // b_reg already holds the inverted B when subtracting.
                    Ovf  <= (a_reg[W-1] == b_reg[W-1]) &
                            (cs[CHUNK-1] != a_reg[W-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq (W=64). The bench computes the
// expected results with plain 65-bit arithmetic. It drives directed corner
// cases, randomized operations and a reset abort. It also runs a
// back-to-back throughput check.
module tb_cla_multiword_seq;

    localparam int W   = 64;
    localparam int NCH = W / 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
`ifdef CLA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_out;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cla_multiword_seq #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a_in),
        .B        (b_in),
        .Cin      (cin),
`ifdef CLA_SEQ_SUB_EN
        .Sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (s_out),
        .Cout     (cout),
        .Ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check({tag, "_valid_timeout"}, 64'd0, 64'd1);
    endtask

    // Full handshake: present the operands, measure the latency, optionally
    // stall the consumer, check the result, then consume it.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input logic sb, input int stall, input string tag);
        logic [64:0] sum;
        logic [63:0] bb;
        logic        cc;
        logic        ov;
        int          n;
        bb  = sb ? ~b : b;
        cc  = sb ? 1'b1 : ci;
        sum = {1'b0, a} + {1'b0, bb} + 65'(cc);
        ov  = (a[63] == bb[63]) && (sum[63] != a[63]);

        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        cin  = ci;
`ifdef CLA_SEQ_SUB_EN
        sub = sb;
`endif
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        // The block accepts on the next rising edge. Scramble the inputs
        // afterwards: captured operands must not follow them.
        @(negedge clk);
        in_valid = 1'b0;
        a_in = rnd64();
        b_in = rnd64();
        cin  = 1'($urandom);
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NCH));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a_in = rnd64();
            @(negedge clk);
            check({tag, "_hold_s"}, s_out, sum[63:0]);
            check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check({tag, "_s"}, s_out, sum[63:0]);
        check({tag, "_cout"}, 64'(cout), 64'(sum[64]));
        check({tag, "_ovf"}, 64'(ovf), 64'(ov));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int bad;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", s_out, 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0, "wrap");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, "ovf");
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0, "negovf");
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 0, "chunkcarry");
        run_op(rnd64(), rnd64(), 1'b1, 1'b0, 5, "stall");

        // Reset after two chunks have been processed aborts the add.
        in_valid = 1'b1;
        a_in = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in = 64'h1;
        cin = 1'b0;
        wait_ready("abort");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_s", s_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 64'(in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("abort_no_valid", 64'(bad), 64'd0);
        run_op(64'd1, 64'd2, 1'b0, 1'b0, 0, "after_abort");

        // Back-to-back operations with out_ready tied high.
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_in = 64'd10;
        b_in = 64'd20;
        cin = 1'b0;
        wait_ready("tp1");
        t0 = cyc;
        @(negedge clk);
        a_in = 64'd3;
        b_in = 64'd4;
        wait_valid("tp1");
        check("tp_s1", s_out, 64'd30);
        @(negedge clk);
        wait_ready("tp2");
        t1 = cyc;
        check("tp_spacing", 64'(t1 - t0), 64'(NCH + 2));
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("tp2");
        check("tp_s2", s_out, 64'd7);
        @(negedge clk);
        out_ready = 1'b0;

`ifdef CLA_SEQ_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 0, "sub_neg");
        run_op(64'd7, 64'd5, 1'b0, 1'b1, 0, "sub_pos");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 0, "sub_ovf");
`endif

        for (int i = 0; i < 25; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rs;
            ra = rnd64();
            rb = rnd64();
            case ($urandom_range(0, 3))
                0: rb = ~ra;
                1: ra = {$urandom, 32'hFFFF_FFFF};
                default: ;
            endcase
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom), rs, int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
